// File: rtl/genie_mem_bridge_pkg.sv
// Shared types and default sizes for the Genie data-memory bridge.
package genie_mem_bridge_pkg;

   localparam int MB_AW          = 26;
   localparam int MB_DW          = 32;
   localparam int MB_WFIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      MB_IDLE    = 2'd0,
      MB_RD_REQ  = 2'd1,
      MB_RD_WAIT = 2'd2,
      MB_RD_RESP = 2'd3
   } mb_state_e;

endpackage

// File: rtl/genie_mem_bridge_if.sv
// Accelerator-side and memory-side bus bundles of the bridge.
interface genie_acc_if
   import genie_mem_bridge_pkg::*;
#(
   parameter int AW = MB_AW,
   parameter int DW = MB_DW
);
   logic          wvalid;
   logic          wready;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          rvalid;
   logic          rready;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata;

   modport master (
      output wvalid, waddr, wdata,
      output rvalid, raddr,
      input  wready, rready, rdata
   );

   modport slave (
      input  wvalid, waddr, wdata,
      input  rvalid, raddr,
      output wready, rready, rdata
   );
endinterface

interface genie_mem_if
   import genie_mem_bridge_pkg::*;
#(
   parameter int AW = MB_AW,
   parameter int DW = MB_DW
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/genie_wfifo.sv
// Write-posting FIFO; head is presented combinationally.
module genie_wfifo #(
   parameter int W     = 58,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [CW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PW'(1);
         if (do_pop)  rptr_q <= rptr_q + PW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= din_i;
   end
endmodule

// File: rtl/genie_mem_bridge.sv
// Posts Genie writes, serialises reads behind them onto one memory port.
module genie_mem_bridge
   import genie_mem_bridge_pkg::*;
#(
   parameter int AW          = MB_AW,
   parameter int DW          = MB_DW,
   parameter int WFIFO_DEPTH = MB_WFIFO_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   genie_acc_if.slave   acc,
   genie_mem_if.master  mem,
   output logic         idle,
   output logic         err
);
   mb_state_e        state_q, state_d;
   logic [AW-1:0]    raddr_q, raddr_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic             err_q, err_d;
   logic [AW+DW-1:0] head;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   assign push       = acc.wvalid & ~full & ~rst;
   assign acc.wready = push;

   genie_wfifo #(
      .W     (AW + DW),
      .DEPTH (WFIFO_DEPTH)
   ) u_wfifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   ({acc.waddr, acc.wdata}),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      state_d       = state_q;
      raddr_d       = raddr_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      pop           = 1'b0;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      acc.rready    = 1'b0;
      acc.rdata     = '0;
      if (mem.mem_rvalid && state_q != MB_RD_WAIT) err_d = 1'b1;
      unique case (state_q)
         MB_IDLE: begin
            // Posted writes drain before any read is taken.
            if (!empty) begin
               mem.mem_req   = 1'b1;
               mem.mem_we    = 1'b1;
               mem.mem_addr  = head[AW+DW-1:DW];
               mem.mem_wdata = head[DW-1:0];
               pop           = mem.mem_gnt;
            end else if (acc.rvalid) begin
               state_d = MB_RD_REQ;
               raddr_d = acc.raddr;
            end
         end
         MB_RD_REQ: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = raddr_q;
            if (mem.mem_gnt) state_d = MB_RD_WAIT;
         end
         MB_RD_WAIT: begin
            if (mem.mem_rvalid) begin
               rdata_d = mem.mem_rdata;
               state_d = MB_RD_RESP;
            end
         end
         MB_RD_RESP: begin
            acc.rready = 1'b1;
            acc.rdata  = rdata_q;
            state_d    = MB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MB_IDLE;
         raddr_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         raddr_q <= raddr_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign idle = (state_q == MB_IDLE) & empty;
   assign err  = err_q;
endmodule

// File: tb/tb_genie_mem_bridge.sv
// Bench for genie_mem_bridge: directed scenarios plus a random mix.
module tb_genie_mem_bridge;
   import genie_mem_bridge_pkg::*;

   localparam int AW = 26;
   localparam int DW = 32;

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            cyc;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   logic idle;
   logic err;

   always #5 clk = ~clk;

   genie_acc_if #(.AW(AW), .DW(DW)) acc ();
   genie_mem_if #(.AW(AW), .DW(DW)) mif ();

   genie_mem_bridge #(
      .AW          (AW),
      .DW          (DW),
      .WFIFO_DEPTH (4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .acc  (acc),
      .mem  (mif),
      .idle (idle),
      .err  (err)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   txn_t mlog[$];
   txn_t expw[$];
   logic [DW-1:0] mem_aa [logic [AW-1:0]];
   logic [DW-1:0] ref_aa [logic [AW-1:0]];

   bit            rd_busy  = 0;
   int            rd_cnt   = 0;
   logic [AW-1:0] rd_addr  = '0;
   int            lat      = 1;
   bit            lat_rand = 0;
   bit            gnt_en   = 1;
   bit            gnt_rand = 0;
   bit            inject   = 0;

   function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
      return {6'h0, a} ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [DW-1:0] mem_val(logic [AW-1:0] a);
      if (mem_aa.exists(a)) return mem_aa[a];
      return init_val(a);
   endfunction

   function automatic logic [DW-1:0] ref_val(logic [AW-1:0] a);
      if (ref_aa.exists(a)) return ref_aa[a];
      return init_val(a);
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory: logs granted requests, returns reads after lat cycles.
   always @(posedge clk) begin
      txn_t t;
      cyc++;
      if (rst) begin
         rd_busy = 0;
      end else if (mif.mem_req === 1'b1 && mif.mem_gnt === 1'b1) begin
         t.we   = mif.mem_we;
         t.addr = mif.mem_addr;
         t.data = mif.mem_wdata;
         t.cyc  = cyc;
         mlog.push_back(t);
         if (mif.mem_we) begin
            mem_aa[mif.mem_addr] = mif.mem_wdata;
         end else begin
            rd_busy = 1;
            rd_addr = mif.mem_addr;
            rd_cnt  = lat_rand ? int'($urandom_range(1, 3)) : lat;
         end
      end
   end

   always @(negedge clk) begin
      mif.mem_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_en;
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata  = '0;
      if (inject) begin
         mif.mem_rvalid = 1'b1;
         mif.mem_rdata  = 32'hFFFF_FFFF;
         inject         = 0;
      end else if (rd_busy) begin
         if (rd_cnt <= 1) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = mem_val(rd_addr);
            rd_busy        = 0;
         end else begin
            rd_cnt--;
         end
      end
   end

   task automatic do_write(input logic [AW-1:0] a,
                           input logic [DW-1:0] d,
                           input int budget,
                           output int waits);
      bit   ok;
      txn_t t;
      ok         = 0;
      waits      = 0;
      acc.wvalid = 1'b1;
      acc.waddr  = a;
      acc.wdata  = d;
      while (waits < budget) begin
         #1;
         if (acc.wready === 1'b1) ok = 1;
         @(posedge clk);
         #1;
         if (ok) break;
         waits++;
      end
      acc.wvalid = 1'b0;
      chk($sformatf("wr_accept_%0h", a), 64'(ok), 64'd1);
      if (ok) begin
         t.we = 1; t.addr = a; t.data = d; t.cyc = 0;
         expw.push_back(t);
         ref_aa[a] = d;
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a,
                          input int budget,
                          output logic [DW-1:0] d,
                          output int waits);
      bit got;
      logic [DW-1:0] exp;
      got        = 0;
      waits      = 0;
      d          = '0;
      exp        = ref_val(a);
      acc.rvalid = 1'b1;
      acc.raddr  = a;
      while (waits < budget) begin
         #1;
         if (acc.rready === 1'b1) begin
            got = 1;
            d   = acc.rdata;
         end
         @(posedge clk);
         #1;
         if (got) break;
         waits++;
      end
      acc.rvalid = 1'b0;
      chk($sformatf("rd_done_%0h", a), 64'(got), 64'd1);
      chk($sformatf("rd_data_%0h", a), 64'(d), 64'(exp));
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (idle !== 1'b1 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({"idle_", tag}, 64'(idle), 64'd1);
   endtask

   task automatic cmp_writes(input string tag);
      txn_t w[$];
      int   n;
      foreach (mlog[i]) if (mlog[i].we) w.push_back(mlog[i]);
      chk({tag, "_wcount"}, 64'(w.size()), 64'(expw.size()));
      n = (w.size() < expw.size()) ? w.size() : expw.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_waddr%0d", tag, i), 64'(w[i].addr), 64'(expw[i].addr));
         chk($sformatf("%s_wdata%0d", tag, i), 64'(w[i].data), 64'(expw[i].data));
      end
      mlog.delete();
      expw.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            w;
      int            n;
      int            k;
      logic [DW-1:0] d;
      logic [AW-1:0] a;

      rst            = 1'b1;
      acc.wvalid     = 1'b1;
      acc.rvalid     = 1'b1;
      acc.waddr      = '0;
      acc.wdata      = '0;
      acc.raddr      = '0;
      mif.mem_gnt    = 1'b0;
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata  = '0;

      // 1: reset with requests pending
      @(posedge clk);
      #2;
      chk("rst_wready", 64'(acc.wready), 64'd0);
      chk("rst_rready", 64'(acc.rready), 64'd0);
      chk("rst_mem_req", 64'(mif.mem_req), 64'd0);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      acc.wvalid = 1'b0;
      acc.rvalid = 1'b0;
      #1;
      chk("post_rst_idle", 64'(idle), 64'd1);
      chk("post_rst_err", 64'(err), 64'd0);
      chk("post_rst_rready", 64'(acc.rready), 64'd0);
      chk("post_rst_rdata", 64'(acc.rdata), 64'd0);
      chk("post_rst_mem_req", 64'(mif.mem_req), 64'd0);

      // 2: single write
      do_write(26'h010, 32'hDEADBEEF, 4, w);
      chk("w1_wait", 64'(w), 64'd0);
      #1;
      chk("w1_req", 64'(mif.mem_req), 64'd1);
      chk("w1_we", 64'(mif.mem_we), 64'd1);
      chk("w1_addr", 64'(mif.mem_addr), 64'h010);
      chk("w1_wdata", 64'(mif.mem_wdata), 64'hDEADBEEF);
      chk("w1_busy", 64'(idle), 64'd0);
      @(posedge clk);
      #1;
      chk("w1_idle_t2", 64'(idle), 64'd1);
      cmp_writes("w1");

      // 3: six writes into a stalled memory
      gnt_en = 0;
      for (int i = 0; i < 4; i++) begin
         do_write(26'h200 + 26'(i), 32'h1000 + i, 1, w);
         chk($sformatf("w6_first_try%0d", i), 64'(w), 64'd0);
      end
      acc.wvalid = 1'b1;
      acc.waddr  = 26'h204;
      acc.wdata  = 32'h1004;
      #1;
      chk("w6_full_stall", 64'(acc.wready), 64'd0);
      @(posedge clk);
      #1;
      chk("w6_still_stall", 64'(acc.wready), 64'd0);
      chk("w6_not_idle", 64'(idle), 64'd0);
      gnt_en = 1;
      do_write(26'h204, 32'h1004, 10, w);
      do_write(26'h205, 32'h1005, 10, w);
      wait_idle("w6", 20);
      n = mlog.size();
      chk("w6_mlog_n", 64'(n), 64'd6);
      for (int i = 1; i < n; i++)
         chk($sformatf("w6_gap%0d", i), 64'(mlog[i].cyc - mlog[i-1].cyc), 64'd1);
      cmp_writes("w6");

      // 4: read after write, slow memory
      gnt_en = 0;
      lat    = 3;
      do_write(26'h100, 32'h5, 4, w);
      fork
         begin
            repeat (3) @(posedge clk);
            gnt_en = 1;
         end
      join_none
      do_read(26'h100, 30, d, n);
      chk("raw_rdata", 64'(d), 64'h5);
      n = mlog.size();
      chk("raw_mlog_n", 64'(n), 64'd2);
      if (n >= 2) begin
         chk("raw_first_we", 64'(mlog[n-2].we), 64'd1);
         chk("raw_second_we", 64'(mlog[n-1].we), 64'd0);
         chk("raw_rd_addr", 64'(mlog[n-1].addr), 64'h100);
      end
      wait_idle("raw", 10);
      cmp_writes("raw");

      // 5: eight back-to-back reads, zero-wait memory
      lat = 1;
      for (int i = 0; i < 8; i++) begin
         do_read(26'(i), 20, d, n);
         chk($sformatf("rd8_lat%0d", i), 64'(n), 64'd3);
      end
      wait_idle("rd8", 10);
      mlog.delete();

      // 6: simultaneous read and write, then stray return
      acc.wvalid = 1'b1;
      acc.waddr  = 26'h30;
      acc.wdata  = 32'h1234_5678;
      acc.rvalid = 1'b1;
      acc.raddr  = 26'h20;
      #1;
      chk("rw_wready", 64'(acc.wready), 64'd1);
      begin
         txn_t t;
         t.we = 1; t.addr = 26'h30; t.data = 32'h1234_5678; t.cyc = 0;
         expw.push_back(t);
         ref_aa[26'h30] = 32'h1234_5678;
      end
      @(posedge clk);
      #1;
      acc.wvalid = 1'b0;
      do_read(26'h20, 20, d, n);
      wait_idle("rw", 10);
      n = mlog.size();
      chk("rw_mlog_n", 64'(n), 64'd2);
      if (n >= 2) begin
         chk("rw_rd_first", 64'(mlog[0].we), 64'd0);
         chk("rw_rd_addr", 64'(mlog[0].addr), 64'h20);
         chk("rw_wr_second", 64'(mlog[1].we), 64'd1);
      end
      cmp_writes("rw");
      chk("err_before", 64'(err), 64'd0);
      inject = 1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("err_set", 64'(err), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("err_held", 64'(err), 64'd1);
      chk("err_idle", 64'(idle), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("err_cleared", 64'(err), 64'd0);

      // random mix with random grant and latency
      gnt_rand = 1;
      lat_rand = 1;
      for (int i = 0; i < 40; i++) begin
         a = 26'($urandom_range(0, 15));
         k = int'($urandom_range(0, 2));
         if (k != 0) do_write(a, $urandom, 60, w);
         else        do_read(a, 80, d, n);
      end
      wait_idle("rand", 100);
      cmp_writes("rand");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
